// File: rtl/cache_repl_ctrl.sv
// cache_repl_ctrl: sequences LRU read, victim choice, refill handshake and MRU update for one access at a time.
module cache_repl_ctrl #(
  parameter int NUM_OF_SETS_SQRT = 2,
  parameter int INDEX_WIDTH      = 12,
  parameter int CNT_WIDTH        = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [INDEX_WIDTH-1:0]      req_index_i,
  input  logic                        req_hit_i,
  input  logic [NUM_OF_SETS_SQRT-1:0] req_way_i,
  output logic                        resp_valid_o,
  input  logic                        resp_ready_i,
  output logic [NUM_OF_SETS_SQRT-1:0] resp_way_o,
  output logic                        resp_miss_o,
  output logic                        refill_req_o,
  output logic [INDEX_WIDTH-1:0]      refill_index_o,
  output logic [NUM_OF_SETS_SQRT-1:0] refill_way_o,
  input  logic                        refill_ack_i,
  output logic [INDEX_WIDTH-1:0]      lru_addr_o,
  output logic                        lru_we_o,
  output logic [NUM_OF_SETS_SQRT-1:0] lru_set_o,
  input  logic [NUM_OF_SETS_SQRT-1:0] lru_victim_i,
  output logic [CNT_WIDTH-1:0]        hit_cnt_o,
  output logic [CNT_WIDTH-1:0]        miss_cnt_o
);
  typedef enum logic [2:0] {IDLE, READ, DECIDE, REFILL, UPDATE, RESP} state_t;
  state_t                      state;
  logic                        hit_q;
  logic [NUM_OF_SETS_SQRT-1:0] way_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= IDLE;
      hit_q          <= 1'b0;
      way_q          <= '0;
      req_ready_o    <= 1'b1;
      resp_valid_o   <= 1'b0;
      resp_way_o     <= '0;
      resp_miss_o    <= 1'b0;
      refill_req_o   <= 1'b0;
      refill_index_o <= '0;
      refill_way_o   <= '0;
      lru_addr_o     <= '0;
      lru_we_o       <= 1'b0;
      lru_set_o      <= '0;
      hit_cnt_o      <= '0;
      miss_cnt_o     <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid_i) begin
          req_ready_o <= 1'b0;
          lru_addr_o  <= req_index_i;
          hit_q       <= req_hit_i;
          way_q       <= req_way_i;
          state       <= READ;
        end
        READ: state <= DECIDE;
        DECIDE: if (hit_q) begin
          lru_we_o  <= 1'b1;
          lru_set_o <= way_q;
          state     <= UPDATE;
        end else begin
          way_q          <= lru_victim_i;
          refill_index_o <= lru_addr_o;
          refill_way_o   <= lru_victim_i;
          refill_req_o   <= 1'b1;
          state          <= REFILL;
        end
        REFILL: if (refill_ack_i) begin
          refill_req_o <= 1'b0;
          lru_we_o     <= 1'b1;
          lru_set_o    <= way_q;
          state        <= UPDATE;
        end
        UPDATE: begin
          lru_we_o     <= 1'b0;
          hit_cnt_o    <= hit_q ? hit_cnt_o + 1'b1 : hit_cnt_o;
          miss_cnt_o   <= hit_q ? miss_cnt_o : miss_cnt_o + 1'b1;
          resp_valid_o <= 1'b1;
          resp_way_o   <= way_q;
          resp_miss_o  <= !hit_q;
          state        <= RESP;
        end
        RESP: if (resp_ready_i) begin
          resp_valid_o <= 1'b0;
          req_ready_o  <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_repl_ctrl.sv
// tb_cache_repl_ctrl: directed and random accesses checked against a timestamp-based LRU reference.
module tb_cache_repl_ctrl;
  localparam int W = 2, IW = 12, CW = 4;
  logic clk_i = 0, rst_i = 1, req_valid_i = 0, req_hit_i = 0, resp_ready_i = 0, refill_ack_i = 0;
  logic [IW-1:0] req_index_i = '0;
  logic [W-1:0] req_way_i = '0, lru_victim_i = '0;
  logic req_ready_o, resp_valid_o, resp_miss_o, refill_req_o, lru_we_o;
  logic [W-1:0] resp_way_o, refill_way_o, lru_set_o;
  logic [IW-1:0] refill_index_o, lru_addr_o;
  logic [CW-1:0] hit_cnt_o, miss_cnt_o;
  int checks = 0, errors = 0, we_cnt = 0, tick = 0, exp_hit = 0, exp_miss = 0;
  int stamp [0:(1<<IW)-1][0:3];

  cache_repl_ctrl #(.NUM_OF_SETS_SQRT(W), .INDEX_WIDTH(IW), .CNT_WIDTH(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_index_i(req_index_i), .req_hit_i(req_hit_i), .req_way_i(req_way_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_way_o(resp_way_o),
    .resp_miss_o(resp_miss_o), .refill_req_o(refill_req_o), .refill_index_o(refill_index_o),
    .refill_way_o(refill_way_o), .refill_ack_i(refill_ack_i), .lru_addr_o(lru_addr_o),
    .lru_we_o(lru_we_o), .lru_set_o(lru_set_o), .lru_victim_i(lru_victim_i),
    .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o));

  always #5 clk_i = ~clk_i;

  // Least-recently-used way is the one with the oldest use stamp; ties go to the lowest way.
  function automatic int lru_of(input int idx);
    int best = 0;
    for (int w = 1; w < 4; w++) if (stamp[idx][w] < stamp[idx][best]) best = w;
    return best;
  endfunction

  always @(posedge clk_i) begin
    lru_victim_i <= W'(lru_of(int'(lru_addr_o)));
    if (lru_we_o) begin
      tick <= tick + 1;
      stamp[lru_addr_o][lru_set_o] <= tick + 1;
      we_cnt <= we_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic access(input int idx, input bit hit, input int way, input int ack_d,
                        input int rdy_d, input bit hold, input bit abort);
    int exp_way, we0;
    req_valid_i = 1; req_index_i = IW'(idx); req_hit_i = hit; req_way_i = W'(way);
    chk("ready_idle", 32'(req_ready_o), 1);
    we0 = we_cnt;
    cyc();
    if (!hold) req_valid_i = 0;
    chk("ready_busy", 32'(req_ready_o), 0);
    chk("addr_read", 32'(lru_addr_o), idx);
    cyc();
    chk("decide_quiet", {refill_req_o, lru_we_o, resp_valid_o, req_ready_o}, 0);
    chk("addr_decide", 32'(lru_addr_o), idx);
    exp_way = hit ? way : lru_of(idx);
    cyc();
    if (!hit) begin
      chk("refill_req", 32'(refill_req_o), 1);
      chk("refill_index", 32'(refill_index_o), idx);
      chk("refill_way", 32'(refill_way_o), exp_way);
      chk("we_in_refill", 32'(lru_we_o), 0);
      if (abort) begin
        rst_i = 1;
        #1;
        chk("abort_refill_req", 32'(refill_req_o), 0);
        chk("abort_ready", 32'(req_ready_o), 1);
        chk("abort_cnts", {hit_cnt_o, miss_cnt_o}, 0);
        exp_hit = 0; exp_miss = 0;
        @(negedge clk_i);
        rst_i = 0;
        req_valid_i = 0;
        chk("abort_no_we", 32'(we_cnt - we0), 0);
        return;
      end
      for (int i = 0; i < ack_d; i++) begin
        cyc();
        chk("refill_hold", 32'(refill_req_o), 1);
        chk("refill_addr_hold", 32'(lru_addr_o), idx);
      end
      refill_ack_i = 1;
      cyc();
      refill_ack_i = 0;
    end
    chk("upd_we", 32'(lru_we_o), 1);
    chk("upd_addr", 32'(lru_addr_o), idx);
    chk("upd_set", 32'(lru_set_o), exp_way);
    chk("upd_refill_low", {refill_req_o, resp_valid_o}, 0);
    cyc();
    if (hit) exp_hit++; else exp_miss++;
    chk("resp_valid", 32'(resp_valid_o), 1);
    chk("resp_way", 32'(resp_way_o), exp_way);
    chk("resp_miss", 32'(resp_miss_o), 32'(!hit));
    chk("hit_cnt", 32'(hit_cnt_o), exp_hit % (1 << CW));
    chk("miss_cnt", 32'(miss_cnt_o), exp_miss % (1 << CW));
    chk("we_pulses", 32'(we_cnt - we0), 1);
    chk("we_dropped", 32'(lru_we_o), 0);
    for (int i = 0; i < rdy_d; i++) begin
      cyc();
      chk("resp_hold", {resp_valid_o, resp_miss_o, req_ready_o}, {1'b1, !hit, 1'b0});
      chk("resp_way_hold", 32'(resp_way_o), exp_way);
      chk("resp_addr_hold", 32'(lru_addr_o), idx);
    end
    resp_ready_i = 1;
    cyc();
    resp_ready_i = 0;
    chk("resp_done", {resp_valid_o, req_ready_o}, 2'b01);
  endtask

  initial begin
    repeat (2) @(negedge clk_i);
    chk("rst_ready", 32'(req_ready_o), 1);
    chk("rst_flags", {resp_valid_o, resp_miss_o, refill_req_o, lru_we_o}, 0);
    chk("rst_vals", {resp_way_o, refill_way_o, lru_set_o, refill_index_o, lru_addr_o}, 0);
    chk("rst_cnts", {hit_cnt_o, miss_cnt_o}, 0);
    rst_i = 0;
    @(negedge clk_i);
    access(5, 1, 2, 0, 0, 0, 0);
    access(7, 0, 3, 4, 0, 0, 0);
    for (int w = 0; w < 4; w++) access(3, 1, w, 0, 0, 0, 0);
    access(3, 0, 2, 0, 0, 0, 0);
    chk("victim_idx3", 32'(resp_way_o), 0);
    access(9, 1, 1, 0, 3, 1, 0);
    access(9, 1, 3, 0, 0, 0, 0);
    access(11, 0, 0, 2, 0, 0, 1);
    access(11, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) access(20, 1, int'($urandom_range(0, 3)), 0, 0, 0, 0);
    chk("hit_wrap", 32'(hit_cnt_o), 1);
    for (int i = 0; i < 40; i++)
      access(100 + int'($urandom_range(0, 7)), bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 0, 0);
    req_valid_i = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
